led_chaser: RTL and testbench
=============================

# led_chaser

Parametrised LED chaser for the FPGA board top level. It generalises the fixed 8-LED pisca-pisca to N LEDs with a built-in clock prescaler and four animation modes: shift, rotate, bounce and bar fill. Freeze and direction controls are kept. A step pulse and a wrap pulse are exported so the top level can drive SEG or LCD debug fields. It sits between the SWI switches and the LED bus.

## Interface
- NLEDS, 8, number of LEDs (>= 2)
- DIV, 100000000, clk_2 cycles per animation step (>= 1; DIV=1 steps every cycle)

- clk_2  in  1  single clock, all state on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- freeze  in  1  1 = hold pattern and prescaler
- dir  in  1  0 = move toward LSB (right), 1 = toward MSB (left); ignored in BOUNCE
- mode  in  2  0 SHIFT, 1 ROTATE, 2 BOUNCE, 3 BAR
- led  out  NLEDS  current pattern (registered)
- step  out  1  one-cycle pulse, high in the cycle led shows a newly advanced/loaded value
- wrap  out  1  one-cycle pulse marking completion of a pattern period (see per mode)

## Operation
- Reset values: led = 1<<(NLEDS-1) (MSB only), prescaler cnt = 0, bounce direction bdir = 0 (right), step = 0, wrap = 0.
- Prescaler: cnt width = max(1, clog2(DIV)); counts 0..DIV-1 on each non-frozen edge. A tick occurs on the edge where cnt == DIV-1; cnt then returns to 0.
- freeze=1: cnt, led, bdir hold; step = wrap = 0. No tick can occur while frozen.
- On a tick, step <= 1. Then either reload or advance:
  - If led is illegal for the current mode, led loads the mode start pattern; wrap stays 0.
  - Otherwise led advances per mode.
- mode and dir are sampled only at ticks; changes between ticks have no effect until the next tick.
- Start pattern / legal states:
  - SHIFT: start MSB (dir=0) or LSB (dir=1); legal = one-hot or all-zero.
  - ROTATE: same start; legal = one-hot.
  - BOUNCE: start MSB with bdir=0; legal = one-hot.
  - BAR: start all-zero. Legal = all-zero, or a contiguous run of ones anchored at the fill edge (MSB for dir=0, LSB for dir=1); all-ones is legal for both.
- SHIFT advance: one-hot shifts in dir; shifting out of the edge gives all-zero (a blank step). From all-zero, load the start for dir and pulse wrap.
- ROTATE advance: circular shift in dir. wrap=1 when the bit crosses the edge (bit0 to MSB for dir=0, MSB to bit0 for dir=1).
- BOUNCE advance:
  - bdir=0 with led[0]=1: set bdir=1, led <= 2.
  - bdir=1 with led[NLEDS-1]=1: set bdir=0, led <= MSB>>1, and pulse wrap.
  - Otherwise shift per bdir.
  - Edges are not repeated; the period is 2*(NLEDS-1) ticks.
- BAR advance:
  - dir=0: led <= {1'b1, led[NLEDS-1:1]}.
  - dir=1: led <= {led[NLEDS-2:0], 1'b1}.
  - From all-ones, go to all-zero and pulse wrap.
  - The period is NLEDS+1 ticks.
- On entering BOUNCE from another mode, a legal one-hot keeps the current bdir.
- Reset asserted mid-operation forces reset values asynchronously. The first tick after release occurs on the DIV-th rising edge.

## Timing
- Tick-to-output latency: led, step and wrap update on the same clk_2 edge that completes the tick. There is no extra pipeline stage.
- step/wrap high exactly one cycle per tick. With DIV=1 and freeze=0, step stays high continuously.
- freeze asserted on a tick edge suppresses that tick.
- Deasserting freeze resumes counting from the held cnt. The remaining cycles to the next tick are preserved.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset and prescaler, NLEDS=8, DIV=4, mode=SHIFT, dir=0:
  - After reset, led=8'h80.
  - step pulses on edges 4, 8, 12 after release.
  - led goes 8'h40, then 8'h20, ...
- SHIFT blank, DIV=1, dir=0:
  - From 8'h01, the next tick gives led=8'h00, wrap=0.
  - The tick after gives 8'h80, wrap=1.
- ROTATE and direction change, DIV=1, dir=1:
  - From 8'h80, the next tick gives 8'h01, wrap=1.
  - Switch dir=0 at 8'h04: the next value is 8'h02.
- BOUNCE, DIV=1:
  - Sequence from reset is 80,40,20,10,08,04,02,01,02,...,80,40.
  - wrap=1 exactly when 80→40 after 01 (period 14 ticks).
- BAR plus illegal reload, DIV=1, dir=0:
  - Sequence is 00,80,C0,...,FF,00; wrap on FF→00.
  - Switching to dir=1 at 8'hC0 reloads to 8'h00 with wrap=0.
- Freeze and async reset, DIV=4:
  - Raise freeze for 10 cycles at cnt=2: led, step and cnt hold. After release, the tick occurs 2 cycles later.
  - Assert reset between edges: led=8'h80 immediately, before the next clk_2 edge.

Source files
------------

// File: rtl/led_chaser_if.sv
// Control and display signals between the switch bank, the LED chaser and the LED bus.
// The master drives the animation controls; the slave returns the pattern and the pulses.
interface led_chaser_if #(
    parameter int NLEDS = 8
);
    logic             freeze;
    logic             dir;
    logic [1:0]       mode;
    logic [NLEDS-1:0] led;
    logic             step;
    logic             wrap;

    modport master (output freeze, dir, mode, input led, step, wrap);
    modport slave  (input freeze, dir, mode, output led, step, wrap);
endinterface

// File: rtl/led_chaser.sv
// N-LED chaser with a built-in step prescaler and four animation modes.
// Modes: shift, rotate, bounce and bar fill. step/wrap pulses mark advances and pattern periods.
module led_chaser #(
    parameter int NLEDS = 8,
    parameter int DIV   = 100000000
) (
    input  logic         clk_2,
    input  logic         reset,
    led_chaser_if.slave  bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
    localparam logic [NLEDS-1:0] MSB_ONLY = {1'b1, {(NLEDS-1){1'b0}}};
    localparam logic [NLEDS-1:0] LSB_ONLY = NLEDS'(1);
    localparam logic [NLEDS-1:0] ALL_ONES = '1;

    localparam logic [1:0] M_SHIFT  = 2'd0;
    localparam logic [1:0] M_ROTATE = 2'd1;
    localparam logic [1:0] M_BOUNCE = 2'd2;
    localparam logic [1:0] M_BAR    = 2'd3;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NLEDS-1:0] led_q, led_d;
    logic             bdir_q, bdir_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic             legal;

    function automatic logic is_onehot(input logic [NLEDS-1:0] v);
        return (v != '0) && ((v & (v - NLEDS'(1))) == '0);
    endfunction

    // A bar is a run of ones from the fill edge; mirror to an LSB-anchored run and test it.
    function automatic logic is_bar(input logic [NLEDS-1:0] v, input logic d);
        logic [NLEDS-1:0] x;
        x = d ? v : ~v;
        return (x & (x + NLEDS'(1))) == '0;
    endfunction

    function automatic logic [NLEDS-1:0] start_pat(input logic [1:0] m, input logic d);
        logic [NLEDS-1:0] p;
        case (m)
            M_BAR:    p = '0;
            M_BOUNCE: p = MSB_ONLY;
            default:  p = d ? LSB_ONLY : MSB_ONLY;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            led_q  <= MSB_ONLY;
            bdir_q <= 1'b0;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            bdir_q <= bdir_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        bdir_d = bdir_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        legal  = 1'b0;
        tick   = !bus.freeze && (cnt_q == CNT_LAST);

        if (!bus.freeze) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        if (tick) begin
            step_d = 1'b1;
            case (bus.mode)
                M_SHIFT: legal = is_onehot(led_q) || (led_q == '0);
                M_BAR:   legal = is_bar(led_q, bus.dir);
                default: legal = is_onehot(led_q);
            endcase

            if (!legal) begin
                led_d = start_pat(bus.mode, bus.dir);
                if (bus.mode == M_BOUNCE) begin
                    bdir_d = 1'b0;
                end
            end else begin
                case (bus.mode)
                    M_SHIFT: begin
                        if (led_q == '0) begin
                            led_d  = start_pat(M_SHIFT, bus.dir);
                            wrap_d = 1'b1;
                        end else begin
                            led_d = bus.dir ? (led_q << 1) : (led_q >> 1);
                        end
                    end
                    M_ROTATE: begin
                        if (bus.dir) begin
                            led_d  = {led_q[NLEDS-2:0], led_q[NLEDS-1]};
                            wrap_d = led_q[NLEDS-1];
                        end else begin
                            led_d  = {led_q[0], led_q[NLEDS-1:1]};
                            wrap_d = led_q[0];
                        end
                    end
                    M_BOUNCE: begin
                        // Edge LEDs are shown once per pass: turn around one position early.
                        if (!bdir_q && led_q[0]) begin
                            bdir_d = 1'b1;
                            led_d  = LSB_ONLY << 1;
                        end else if (bdir_q && led_q[NLEDS-1]) begin
                            bdir_d = 1'b0;
                            led_d  = MSB_ONLY >> 1;
                            wrap_d = 1'b1;
                        end else begin
                            led_d = bdir_q ? (led_q << 1) : (led_q >> 1);
                        end
                    end
                    default: begin
                        if (led_q == ALL_ONES) begin
                            led_d  = '0;
                            wrap_d = 1'b1;
                        end else if (bus.dir) begin
                            led_d = {led_q[NLEDS-2:0], 1'b1};
                        end else begin
                            led_d = {1'b1, led_q[NLEDS-1:1]};
                        end
                    end
                endcase
            end
        end
    end

    assign bus.led  = led_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_chaser.sv
// Directed bench for led_chaser: one instance with DIV=4 and one with DIV=1, both 8 LEDs.
module tb_led_chaser;
    logic clk = 1'b0;
    logic r4, r1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    led_chaser_if #(.NLEDS(8)) b4 ();
    led_chaser_if #(.NLEDS(8)) b1 ();

    led_chaser #(.NLEDS(8), .DIV(4)) u_d4 (.clk_2(clk), .reset(r4), .bus(b4.slave));
    led_chaser #(.NLEDS(8), .DIV(1)) u_d1 (.clk_2(clk), .reset(r1), .bus(b1.slave));

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_d1(input logic [1:0] m, input logic d);
        b1.mode = m; b1.dir = d; b1.freeze = 1'b0;
        r1 = 1'b1;
        edge1();
        r1 = 1'b0;
    endtask

    task automatic test_reset();
        r4 = 1'b1; b4.freeze = 1'b0; b4.dir = 1'b0; b4.mode = 2'd0;
        #3;
        checks++;
        if (b4.led !== 8'h80 || b4.step !== 1'b0 || b4.wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset: led=%h step=%b wrap=%b, required led=80 step=0 wrap=0", b4.led, b4.step, b4.wrap);
        end
        edge1();
        r4 = 1'b0;
    endtask

    task automatic test_prescaler();
        logic [7:0] exp_led;
        for (int e = 1; e <= 12; e++) begin
            edge1();
            exp_led = 8'h80 >> (e / 4);
            checks++;
            if (b4.step !== (e % 4 == 0) || b4.led !== exp_led || b4.wrap !== 1'b0) begin
                errors++;
                $display("FAIL prescaler edge %0d: led=%h step=%b wrap=%b, required led=%h step=%b wrap=0",
                         e, b4.led, b4.step, b4.wrap, exp_led, (e % 4 == 0));
            end
        end
    endtask

    task automatic test_shift_blank();
        logic [7:0] exp_led [1:9];
        exp_led = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00, 8'h80};
        reset_d1(2'd0, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            edge1();
            checks++;
            if (b1.led !== exp_led[e] || b1.wrap !== (e == 9) || b1.step !== 1'b1) begin
                errors++;
                $display("FAIL shift edge %0d: led=%h wrap=%b step=%b, required led=%h wrap=%b step=1",
                         e, b1.led, b1.wrap, b1.step, exp_led[e], (e == 9));
            end
        end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_led [1:4];
        exp_led = '{8'h01, 8'h02, 8'h04, 8'h02};
        reset_d1(2'd1, 1'b1);
        for (int e = 1; e <= 4; e++) begin
            edge1();
            checks++;
            if (b1.led !== exp_led[e] || b1.wrap !== (e == 1)) begin
                errors++;
                $display("FAIL rotate edge %0d: led=%h wrap=%b, required led=%h wrap=%b",
                         e, b1.led, b1.wrap, exp_led[e], (e == 1));
            end
            if (e == 3) b1.dir = 1'b0;
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp_led [1:15];
        exp_led = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                    8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
        reset_d1(2'd2, 1'b0);
        for (int e = 1; e <= 15; e++) begin
            edge1();
            checks++;
            if (b1.led !== exp_led[e] || b1.wrap !== (e == 15)) begin
                errors++;
                $display("FAIL bounce edge %0d: led=%h wrap=%b, required led=%h wrap=%b",
                         e, b1.led, b1.wrap, exp_led[e], (e == 15));
            end
        end
    endtask

    task automatic test_bar();
        logic [7:0] exp_led [1:12];
        exp_led = '{8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h00,
                    8'h80, 8'hC0, 8'h00, 8'h01};
        reset_d1(2'd3, 1'b0);
        for (int e = 1; e <= 12; e++) begin
            edge1();
            checks++;
            if (b1.led !== exp_led[e] || b1.wrap !== (e == 8)) begin
                errors++;
                $display("FAIL bar edge %0d: led=%h wrap=%b, required led=%h wrap=%b",
                         e, b1.led, b1.wrap, exp_led[e], (e == 8));
            end
            if (e == 10) b1.dir = 1'b1;
        end
    endtask

    task automatic test_freeze();
        r4 = 1'b1; b4.mode = 2'd0; b4.dir = 1'b0; b4.freeze = 1'b0;
        edge1();
        r4 = 1'b0;
        edge1();
        edge1();
        b4.freeze = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            edge1();
            checks++;
            if (b4.led !== 8'h80 || b4.step !== 1'b0) begin
                errors++;
                $display("FAIL freeze hold %0d: led=%h step=%b, required led=80 step=0", e, b4.led, b4.step);
            end
        end
        b4.freeze = 1'b0;
        edge1();
        checks++;
        if (b4.step !== 1'b0 || b4.led !== 8'h80) begin
            errors++;
            $display("FAIL freeze resume1: led=%h step=%b, required led=80 step=0", b4.led, b4.step);
        end
        edge1();
        checks++;
        if (b4.step !== 1'b1 || b4.led !== 8'h40) begin
            errors++;
            $display("FAIL freeze resume2: led=%h step=%b, required led=40 step=1", b4.led, b4.step);
        end
    endtask

    task automatic test_async_reset();
        #2;
        r4 = 1'b1;
        #1;
        checks++;
        if (b4.led !== 8'h80 || b4.step !== 1'b0) begin
            errors++;
            $display("FAIL async reset: led=%h step=%b, required led=80 step=0", b4.led, b4.step);
        end
        edge1();
        r4 = 1'b0;
    endtask

    initial begin
        r1 = 1'b1;
        b1.freeze = 1'b0; b1.dir = 1'b0; b1.mode = 2'd0;
        test_reset();
        test_prescaler();
        test_shift_blank();
        test_rotate();
        test_bounce();
        test_bar();
        test_freeze();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
